// File: rtl/ov7670_pkg.sv
// Shared constants and state encoding for the OV7670 configuration path.
package ov7670_pkg;

    // Register-field markers inside the configuration table
    localparam logic [7:0] REG_DELAY    = 8'hF0;
    localparam logic [7:0] REG_END      = 8'hFF;

    // SCCB write address of the OV7670
    localparam logic [7:0] OV7670_WR_ID = 8'h42;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ov7670_reg_rom.sv
// OV7670 register table: {reg, val} per entry, synchronous read, 1-cycle latency.
module ov7670_reg_rom
    import ov7670_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [15:0]       o_data
);

    logic [15:0] r_data;

    // Table contents: soft reset, settle delay, QVGA/RGB565 set, end marker
    function automatic logic [15:0] rom_entry(input logic [ADDR_W-1:0] a);
        logic [7:0] a8;
        a8 = 8'(a);
        case (a8)
            8'd0:    rom_entry = 16'h1280;           // COM7: soft reset
            8'd1:    rom_entry = {REG_DELAY, 8'h0A}; // wait 10 ticks after reset
            8'd2:    rom_entry = 16'h1214;           // COM7: QVGA, RGB
            8'd3:    rom_entry = 16'h40D0;           // COM15: RGB565, full range
            8'd4:    rom_entry = 16'h1180;           // CLKRC: use external clock
            8'd5:    rom_entry = 16'h0C04;           // COM3: enable scaling
            8'd6:    rom_entry = 16'h3E19;           // COM14: PCLK divide, manual scale
            8'd7:    rom_entry = 16'h703A;           // SCALING_XSC
            8'd8:    rom_entry = 16'h7135;           // SCALING_YSC
            8'd9:    rom_entry = 16'h7211;           // SCALING_DCWCTR
            8'd10:   rom_entry = 16'h73F1;           // SCALING_PCLK_DIV
            8'd11:   rom_entry = 16'hA202;           // SCALING_PCLK_DELAY
            8'd12:   rom_entry = 16'h8C00;           // RGB444: disabled
            8'd13:   rom_entry = 16'h0400;           // COM1: no CCIR656
            8'd14:   rom_entry = 16'h1438;           // COM9: AGC ceiling
            default: rom_entry = {REG_END, REG_END};
        endcase
    endfunction

    // Registered read so the table maps onto block or distributed ROM
    always_ff @(posedge i_clk) begin
        r_data <= rom_entry(i_addr);
    end

    assign o_data = r_data;

endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 register table and hands one write at a time to the SCCB sender.
module ov7670_config_sequencer
    import ov7670_pkg::*;
#(
    parameter logic [7:0] DEV_ID     = OV7670_WR_ID,
    parameter int         ROM_DEPTH  = 64,
    parameter int         DELAY_UNIT = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       resend,
    input  logic       taken,
    output logic       send,
    output logic [7:0] id,
    output logic [7:0] rega,
    output logic [7:0] value,
    output logic       done
);

    localparam int                ADDR_W   = $clog2(ROM_DEPTH);
    localparam int                CNT_W    = $clog2(255 * DELAY_UNIT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROM_DEPTH - 1);
    localparam logic [CNT_W-1:0]  UNIT     = CNT_W'(DELAY_UNIT);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_run;
    logic               r_send;
    logic               r_done;
    logic [7:0]         r_rega;
    logic [7:0]         r_value;

    logic [15:0]        w_rom_data;
    logic [7:0]         w_rom_reg;
    logic [7:0]         w_rom_val;
    logic               w_is_end;
    logic               w_is_delay;
    logic               w_last;
    logic [CNT_W-1:0]   w_delay_load;

    ov7670_reg_rom #(
        .DEPTH  (ROM_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rom (
        .i_clk  (clk),
        .i_addr (r_idx),
        .o_data (w_rom_data)
    );

    assign w_rom_reg    = w_rom_data[15:8];
    assign w_rom_val    = w_rom_data[7:0];
    assign w_is_end     = (w_rom_reg == REG_END) && (w_rom_val == REG_END);
    assign w_is_delay   = (w_rom_reg == REG_DELAY);
    assign w_last       = (r_idx == LAST_IDX);
    assign w_delay_load = CNT_W'(w_rom_val) * UNIT - CNT_W'(1);

    // Retime reset release onto clk so the FSM starts on a clean edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_run <= 1'b0;
        else         r_run <= 1'b1;
    end

    // Sequencer FSM: fetch/decode table entries, hand writes off, run delays
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_FETCH;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_send  <= 1'b0;
            r_done  <= 1'b0;
            r_rega  <= 8'h00;
            r_value <= 8'h00;
        end else if (r_run) begin
            case (r_state)
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (w_is_end) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_is_delay && (w_rom_val != 8'h00)) begin
                        r_cnt   <= w_delay_load;
                        r_state <= ST_WAIT;
                    end else if (w_is_delay) begin
                        // Zero-length delay: skip straight to the next entry
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end else begin
                        r_rega  <= w_rom_reg;
                        r_value <= w_rom_val;
                        r_send  <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (taken) begin
                        r_send <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_WAIT: begin
                    // Leave on the edge where the countdown reaches zero
                    if (r_cnt <= CNT_W'(1)) begin
                        r_cnt <= '0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_send <= 1'b0;
                    if (resend) begin
                        r_done  <= 1'b0;
                        r_idx   <= '0;
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign send  = r_send;
    assign done  = r_done;
    assign rega  = r_rega;
    assign value = r_value;
    assign id    = DEV_ID;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Directed bench for ov7670_config_sequencer with a scripted sender stub.
module tb_ov7670_config_sequencer;

    localparam int N_WR = 14;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       resend = 1'b0;
    logic       taken  = 1'b0;
    logic       send;
    logic       done;
    logic [7:0] id;
    logic [7:0] rega;
    logic [7:0] value;

    int total  = 0;
    int bad    = 0;
    int writes = 0;

    typedef struct {
        logic [7:0] rg;
        logic [7:0] vl;
        int         hold;   // cycles send is held before the stub answers
        int         gap;    // expected send-low cycles before this write
        bit         rs;     // pulse resend while this write is pending
    } vec_t;

    vec_t v [N_WR];

    ov7670_config_sequencer #(
        .DEV_ID     (8'h42),
        .ROM_DEPTH  (64),
        .DELAY_UNIT (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .resend (resend),
        .taken  (taken),
        .send   (send),
        .id     (id),
        .rega   (rega),
        .value  (value),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count send-low samples until send rises (bounded)
    task automatic wait_send(output int low);
        low = 0;
        while (send !== 1'b1 && low < 500) begin
            low++;
            step();
        end
        chk("send_rise", {31'd0, send}, 32'd1);
        if (send === 1'b1) writes++;
    endtask

    task automatic do_write(input int i, input int gap);
        int low;
        wait_send(low);
        chk($sformatf("gap[%0d]", i), low, gap);
        chk($sformatf("rega[%0d]", i), {24'd0, rega}, {24'd0, v[i].rg});
        chk($sformatf("value[%0d]", i), {24'd0, value}, {24'd0, v[i].vl});
        for (int k = 0; k < v[i].hold; k++) begin
            resend = v[i].rs && (k == 0);
            step();
            resend = 1'b0;
            chk($sformatf("stall_send[%0d]", i), {31'd0, send}, 32'd1);
            chk($sformatf("stall_reg[%0d]", i), {16'd0, rega, value}, {16'd0, v[i].rg, v[i].vl});
        end
        taken = 1'b1;
        step();
        taken = 1'b0;
        chk($sformatf("send_drop[%0d]", i), {31'd0, send}, 32'd0);
    endtask

    task automatic run_pass(input int first_gap);
        writes = 0;
        for (int i = 0; i < N_WR; i++) begin
            do_write(i, (i == 0) ? first_gap : v[i].gap);
        end
        chk("done_e0", {31'd0, done}, 32'd0);
        step();
        chk("done_e1", {31'd0, done}, 32'd0);
        step();
        chk("done_e2", {31'd0, done}, 32'd1);
        for (int k = 0; k < 20; k++) begin
            taken = (k == 3 || k == 4);
            step();
            taken = 1'b0;
            chk("idle_send", {31'd0, send}, 32'd0);
            chk("idle_done", {31'd0, done}, 32'd1);
        end
        chk("write_count", writes, N_WR);
    endtask

    initial begin
        int low;
        v[0]  = '{8'h12, 8'h80, 100, 3,  1'b0};
        v[1]  = '{8'h12, 8'h14, 1,   43, 1'b0};
        v[2]  = '{8'h40, 8'hD0, 0,   2,  1'b0};
        v[3]  = '{8'h11, 8'h80, 3,   2,  1'b1};
        v[4]  = '{8'h0C, 8'h04, 1,   2,  1'b0};
        v[5]  = '{8'h3E, 8'h19, 2,   2,  1'b1};
        v[6]  = '{8'h70, 8'h3A, 1,   2,  1'b0};
        v[7]  = '{8'h71, 8'h35, 0,   2,  1'b0};
        v[8]  = '{8'h72, 8'h11, 1,   2,  1'b0};
        v[9]  = '{8'h73, 8'hF1, 4,   2,  1'b0};
        v[10] = '{8'hA2, 8'h02, 1,   2,  1'b0};
        v[11] = '{8'h8C, 8'h00, 1,   2,  1'b0};
        v[12] = '{8'h04, 8'h00, 2,   2,  1'b0};
        v[13] = '{8'h14, 8'h38, 1,   2,  1'b0};

        // Reset held for 5 cycles
        repeat (5) step();
        chk("rst_send",  {31'd0, send}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_rega",  {24'd0, rega}, 32'h00);
        chk("rst_value", {24'd0, value}, 32'h00);
        chk("rst_id",    {24'd0, id},   32'h42);
        resetn = 1'b1;

        // Pass 1: from reset, with stall, delay entry and busy resend pulses
        run_pass(3);

        // Resend in DONE: done drops at the next edge, full sequence repeats
        resend = 1'b1;
        step();
        resend = 1'b0;
        chk("resend_done", {31'd0, done}, 32'd0);
        chk("resend_send", {31'd0, send}, 32'd0);
        run_pass(2);

        // Reset mid-SEND
        resend = 1'b1;
        step();
        resend = 1'b0;
        wait_send(low);
        chk("r3_rega", {24'd0, rega}, 32'h12);
        step();
        #2;
        resetn = 1'b0;
        #1;
        chk("msend_send", {31'd0, send}, 32'd0);
        chk("msend_rega", {24'd0, rega}, 32'h00);
        chk("msend_val",  {24'd0, value}, 32'h00);
        chk("msend_done", {31'd0, done}, 32'd0);
        repeat (3) step();
        resetn = 1'b1;
        wait_send(low);
        chk("msend_gap",   low, 3);
        chk("msend_rega2", {16'd0, rega, value}, 32'h1280);

        // Reset mid-WAIT: take entry 0, then reset inside the delay
        taken = 1'b1;
        step();
        taken = 1'b0;
        repeat (10) step();
        chk("mwait_send", {31'd0, send}, 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        chk("mwait_rega", {24'd0, rega}, 32'h00);
        chk("mwait_id",   {24'd0, id},   32'h42);
        repeat (3) step();
        resetn = 1'b1;
        wait_send(low);
        chk("mwait_gap",   low, 3);
        chk("mwait_rega2", {16'd0, rega, value}, 32'h1280);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ov7670_config_sequencer.md
# ov7670_config_sequencer

Walks a fixed OV7670 register table and feeds one {device id, register, value} write at a time to the SCCB/I2C sender, using the sender's send/taken handshake. It inserts programmable millisecond delays after entries such as the soft reset. It raises `done` once the whole table has been written. It sits between the top level (`resend` button, `config_done` LED) and the I2C sender instance, and owns the sender's `send`, `id`, `rega` and `value` inputs.

## Interface
- `DEV_ID`, 8'h42: OV7670 SCCB write address, driven constantly on `id`.
- `ROM_DEPTH`, 64: table entries; address width is clog2(ROM_DEPTH).
- `DELAY_UNIT`, 50000: clk cycles per delay tick (1 ms at 50 MHz); benches set 4.
- `clk`  in  1: system clock, same clock as the I2C sender.
- `resetn`  in  1: asynchronous, active-low reset.
- `resend`  in  1: single-cycle pulse; restarts the table from entry 0 (honoured only in DONE).
- `taken`  in  1: from sender; high for one cycle when it latches the current write.
- `send`  out  1: write request to sender; held high until `taken`.
- `id`  out  8: constant `DEV_ID`.
- `rega`  out  8: register address of the current entry.
- `value`  out  8: data byte of the current entry.
- `done`  out  1: high when the table is complete, until `resend` or reset.

## Operation
- Table entry = 16 bits {reg, val}. Special encodings:
  - {8'hF0, N}: delay of N × `DELAY_UNIT` cycles; no bus write.
  - {8'hFF, 8'hFF}: end of table.
- Entry 0 = {12,80} (soft reset). Entry 1 = {F0,0A}. Entries from 2 onward are the QVGA/RGB565 set, terminated by {FF,FF}.
- FSM states: FETCH, DECODE, SEND, WAIT, DONE. Reset state is FETCH with index 0.
- **FETCH**: index is presented to the ROM; next state is DECODE.
- **DECODE**: ROM data is valid.
  - End marker → DONE.
  - Delay marker with N > 0 → load counter with N × `DELAY_UNIT` − 1, go to WAIT.
  - Delay marker with N = 0 → index+1, go to FETCH.
  - Otherwise → latch `rega`/`value`, go to SEND.
- **SEND**: `send` = 1 and `rega`/`value` are held stable. When `taken` is sampled high: index+1, go to FETCH.
- **WAIT**: counter decrements each cycle. At 0: index+1, go to FETCH.
- **DONE**: `done` = 1, `send` = 0. `resend` sets index to 0 and goes to FETCH, clearing `done` the next cycle.
- **Index wrap**: if the index reaches ROM_DEPTH−1 without hitting an end marker, that entry is executed normally and the FSM then goes to DONE. The index never wraps to 0 on its own.
- **Ignored inputs**:
  - `resend` outside DONE is ignored (no queuing).
  - `taken` outside SEND is ignored.
- **Reset mid-operation**: `resetn` low at any time clears all state at once, including mid-SEND and mid-WAIT. The table restarts from entry 0 after release.
- The delay counter is wide enough for 255 × `DELAY_UNIT`; product width is computed from the parameters.

## Timing
- Reset values: `send` = 0, `done` = 0, `rega` = 8'h00, `value` = 8'h00. `id` = `DEV_ID` always.
- All outputs are registered.
- First `send` rises 3 rising edges after `resetn` deasserts (FETCH, DECODE, SEND entry).
- **`taken` handshake**: `taken` sampled at edge e →
  - `send` low from e;
  - DECODE at e+1;
  - `send` high again at e+2.
  - So `send` is low for exactly 2 cycles between consecutive writes.
- **Delay entry**: `send` stays low for N × `DELAY_UNIT` + 3 cycles between the surrounding writes, counted from the last `taken` edge to the next `send` rise, i.e. 2 + N × `DELAY_UNIT` + 1.
- `done` rises 2 cycles after the last `taken`.
- **`resend` in DONE**: `done` falls at the next edge; `send` rises 3 edges after the `resend` edge.

## Structure
- Shared package `ov7670_pkg`:
  - `REG_DELAY` = 8'hF0;
  - `REG_END` = 8'hFF;
  - `OV7670_WR_ID` = 8'h42;
  - FSM state typedef.
- Sub-module `ov7670_reg_rom`: synchronous-read ROM, clk/addr in, 16-bit data out, 1-cycle latency, holding the table. The sequencer contains the FSM, index and delay counter only.

## Test plan
- **Reset**: hold `resetn` low 5 cycles → `send` = 0, `done` = 0, `rega` = 00, `value` = 00, `id` = 42. After release, `send` rises on the 3rd edge with `rega` = 12, `value` = 80.
- **Stalled sender**: stub withholds `taken` for 100 cycles → `send` stays high and `rega`/`value` stay stable throughout. One-cycle `taken` → `send` low for exactly 2 cycles.
- **Delay entry**: `DELAY_UNIT` = 4; {F0,0A} after entry 0 → `send` low for 43 cycles, then `rega` = entry 2 register.
- **Completion**: stub returns `taken` after 1 cycle for every write → writes to the sender equal the number of non-marker entries. `done` rises 2 cycles after the last `taken`, and `send` is never asserted again.
- **resend**: pulse while busy → ignored, sequence unchanged. Pulse in DONE → `done` drops, the sequence restarts at {12,80}, and the full sequence repeats identically.
- **Reset mid-SEND and mid-WAIT**: drop `resetn` → `send` falls asynchronously. Restart begins from entry 0.
